// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator between execute and the data memory port.
// Takes one request at a time over a valid/ready handshake and issues a single
// doubleword read (loads) or a sized byte write (stores). Load data is aligned and
// sign/zero-extended, then one response per request is returned over a second
// valid/ready handshake.
// Ports:
//   iClock, iReset      clock, asynchronous active-high reset
//   iReqValid/oReqReady request handshake; iReqWr, iReqFunct3, iReqAddr, iReqWrData
//   oMemRdEn, oMemRdAddrLoad, iMemRdDataLoad   load read port (data one cycle after enable)
//   oMemWrEn, oMemWrAddr, oMemWrData, oMemWrLen write port (len in bytes 1/2/4/8)
//   oRespValid/iRespReady response handshake; oRespData, oRespErr
// Build option: define LSU_MISALIGN_CHECK_EN to turn misaligned accesses into an
// error response with no memory access. Without it misaligned accesses proceed.
module lsu_mem_initiator #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iReqWr,
  input  logic [2:0]        iReqFunct3,
  input  logic [ADDR_W-1:0] iReqAddr,
  input  logic [DATA_W-1:0] iReqWrData,
  output logic              oMemRdEn,
  output logic [ADDR_W-1:0] oMemRdAddrLoad,
  input  logic [DATA_W-1:0] iMemRdDataLoad,
  output logic              oMemWrEn,
  output logic [ADDR_W-1:0] oMemWrAddr,
  output logic [DATA_W-1:0] oMemWrData,
  output logic [7:0]        oMemWrLen,
  output logic              oRespValid,
  input  logic              iRespReady,
  output logic [DATA_W-1:0] oRespData,
  output logic              oRespErr
);

  localparam int unsigned SHAMT_W = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DATA  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wrdata_q;
  logic                req_fire;
  logic                misalign;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_ext;

  assign req_fire = (state_q == IDLE) && iReqValid;

  // Access-size alignment check on the incoming request
`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (iReqFunct3[1:0])
      2'b01:   misalign = iReqAddr[0];
      2'b10:   misalign = |iReqAddr[1:0];
      2'b11:   misalign = |iReqAddr[2:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Byte-align the returned doubleword; bytes shifted past the top read as zero
  assign shamt   = {addr_q[2:0], 3'b000};
  assign shifted = iMemRdDataLoad >> shamt;

  // Size extraction and sign/zero extension by funct3
  always_comb begin
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}},         shifted[7:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}},        shifted[15:0]};
      3'b110:  load_ext = {{(DATA_W-32){1'b0}},        shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // State register
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iReqValid) begin
          if (misalign)    state_d = RESP;
          else if (iReqWr) state_d = WR_ISSUE;
          else             state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA:  state_d = RESP;
      WR_ISSUE: state_d = RESP;
      RESP:     if (iRespReady) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and request fields
  always_comb begin
    oReqReady      = 1'b0;
    oMemRdEn       = 1'b0;
    oMemRdAddrLoad = '0;
    oMemWrEn       = 1'b0;
    oMemWrAddr     = '0;
    oMemWrData     = '0;
    oMemWrLen      = '0;
    oRespValid     = 1'b0;
    case (state_q)
      IDLE:     oReqReady = 1'b1;
      RD_ISSUE: begin
        oMemRdEn       = 1'b1;
        oMemRdAddrLoad = {addr_q[ADDR_W-1:3], 3'b000};
      end
      WR_ISSUE: begin
        oMemWrEn   = 1'b1;
        oMemWrAddr = addr_q;
        oMemWrData = wrdata_q;
        oMemWrLen  = 8'd1 << funct3_q[1:0];
      end
      RESP:     oRespValid = 1'b1;
      default:  oReqReady = 1'b0;
    endcase
  end

  // Request capture and response registers; stores and errors respond with data 0
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      funct3_q  <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      oRespData <= '0;
      oRespErr  <= 1'b0;
    end else if (req_fire) begin
      funct3_q  <= iReqFunct3;
      addr_q    <= iReqAddr;
      wrdata_q  <= iReqWrData;
      oRespData <= '0;
      oRespErr  <= misalign;
    end else if (state_q == RD_DATA) begin
      oRespData <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: expected responses are queued when a
// request is driven and compared when the response appears.
module tb_lsu_mem_initiator;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } resp_t;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic        iReqWr = 1'b0;
  logic [2:0]  iReqFunct3 = 3'b000;
  logic [63:0] iReqAddr = '0;
  logic [63:0] iReqWrData = '0;
  logic        oMemRdEn;
  logic [63:0] oMemRdAddrLoad;
  logic [63:0] rd_q = '0;
  logic        oMemWrEn;
  logic [63:0] oMemWrAddr;
  logic [63:0] oMemWrData;
  logic [7:0]  oMemWrLen;
  logic        oRespValid;
  logic        iRespReady = 1'b1;
  logic [63:0] oRespData;
  logic        oRespErr;

  logic [63:0] mem_dword = '0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  resp_t       sb[$];

  lsu_mem_initiator #(.ADDR_W(64), .DATA_W(64)) dut (
    .iClock(iClock), .iReset(iReset),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWr(iReqWr),
    .iReqFunct3(iReqFunct3), .iReqAddr(iReqAddr), .iReqWrData(iReqWrData),
    .oMemRdEn(oMemRdEn), .oMemRdAddrLoad(oMemRdAddrLoad), .iMemRdDataLoad(rd_q),
    .oMemWrEn(oMemWrEn), .oMemWrAddr(oMemWrAddr), .oMemWrData(oMemWrData),
    .oMemWrLen(oMemWrLen), .oRespValid(oRespValid), .iRespReady(iRespReady),
    .oRespData(oRespData), .oRespErr(oRespErr)
  );

  always #5 iClock = ~iClock;

  // Registered memory: data appears the cycle after the read enable
  always @(posedge iClock) begin
    if (oMemRdEn) rd_q <= mem_dword;
    if (oMemRdEn) rd_pulses <= rd_pulses + 1;
    if (oMemWrEn) wr_pulses <= wr_pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-by-byte reference for an aligned/extended load
  function automatic logic [63:0] model_load(input logic [63:0] dw, input logic [63:0] a,
                                             input logic [2:0] f3);
    int          sz;
    int          off;
    logic [63:0] r;
    sz  = 1 << f3[1:0];
    off = int'(a[2:0]);
    r   = '0;
    for (int i = 0; i < 8; i++)
      if (i < sz && off + i < 8) r[8*i +: 8] = dw[8*(off+i) +: 8];
    if (!f3[2] && sz < 8 && r[8*sz-1])
      for (int i = 0; i < 64; i++) if (i >= 8*sz) r[i] = 1'b1;
    return r;
  endfunction

  // Drive one request; returns at the negedge following the accepting edge
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] d, input logic push, input logic [63:0] ed,
                       input logic ee);
    resp_t r;
    @(negedge iClock);
    chk("req_ready_idle", 64'(oReqReady), 64'd1);
    iReqValid  = 1'b1;
    iReqWr     = wr;
    iReqFunct3 = f3;
    iReqAddr   = a;
    iReqWrData = d;
    if (push) begin
      r.data = ed;
      r.err  = ee;
      sb.push_back(r);
    end
    @(negedge iClock);
    iReqValid = 1'b0;
  endtask

  // Wait (bounded) for a response and compare it against the scoreboard head
  task automatic wait_resp(input int exp_lat, input string tag);
    int    n;
    resp_t r;
    n = 0;
    while (!oRespValid && n < 12) begin
      @(negedge iClock);
      n++;
    end
    chk({tag, "_valid"}, 64'(oRespValid), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    n_checks++;
    assert (sb.size() > 0) else begin
      n_errors++;
      $error("FAIL %s_scoreboard: observed response with %0d expected entries, required 1", tag, sb.size());
    end
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, "_data"}, oRespData, r.data);
      chk({tag, "_err"}, 64'(oRespErr), 64'(r.err));
    end
  endtask

  // Handshake completes on the next edge with iRespReady high
  task automatic finish_resp(input string tag);
    @(negedge iClock);
    chk({tag, "_valid_drop"}, 64'(oRespValid), 64'd0);
    chk({tag, "_ready_back"}, 64'(oReqReady), 64'd1);
  endtask

  initial begin
    int          base;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] hold;
    int          sz;

    // Reset state
    repeat (2) @(negedge iClock);
    chk("rst_rden", 64'(oMemRdEn), 64'd0);
    chk("rst_wren", 64'(oMemWrEn), 64'd0);
    chk("rst_respvalid", 64'(oRespValid), 64'd0);
    chk("rst_respdata", oRespData, 64'd0);
    chk("rst_resperr", 64'(oRespErr), 64'd0);
    iReset = 1'b0;
    @(negedge iClock);
    chk("rst_reqready", 64'(oReqReady), 64'd1);

    // LB with negative byte
    mem_dword = 64'h0000_0000_8000_0000;
    issue(1'b0, 3'b000, 64'h8000_0003, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    chk("lb_rden", 64'(oMemRdEn), 64'd1);
    chk("lb_rdaddr", oMemRdAddrLoad, 64'h8000_0000);
    chk("lb_wren", 64'(oMemWrEn), 64'd0);
    wait_resp(2, "lb");
    finish_resp("lb");

    // LWU from upper word
    mem_dword = 64'hDEAD_BEEF_1234_5678;
    issue(1'b0, 3'b110, 64'h8000_0004, '0, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0);
    chk("lwu_rdaddr", oMemRdAddrLoad, 64'h8000_0000);
    wait_resp(2, "lwu");
    finish_resp("lwu");

    // SH: single-cycle write
    base = wr_pulses;
    issue(1'b1, 3'b001, 64'h8000_0010, 64'h1234_5678, 1'b1, 64'd0, 1'b0);
    chk("sh_wren", 64'(oMemWrEn), 64'd1);
    chk("sh_wraddr", oMemWrAddr, 64'h8000_0010);
    chk("sh_wrdata", oMemWrData, 64'h1234_5678);
    chk("sh_wrlen", 64'(oMemWrLen), 64'd2);
    chk("sh_rden", 64'(oMemRdEn), 64'd0);
    wait_resp(1, "sh");
    chk("sh_wren_after", 64'(oMemWrEn), 64'd0);
    finish_resp("sh");
    chk("sh_wr_pulses", 64'(wr_pulses - base), 64'd1);

    // Every load funct3 at an aligned offset against the byte model
    for (int f = 0; f < 8; f++) begin
      sz = 1 << f[1:0];
      mem_dword = {$urandom, $urandom};
      a = 64'h8000_0100 + 64'(f * 8) + 64'($urandom_range(0, 7) & ~(sz - 1));
      issue(1'b0, 3'(f), a, '0, 1'b1, model_load(mem_dword, a, 3'(f)), 1'b0);
      chk("ld_rdaddr", oMemRdAddrLoad, {a[63:3], 3'b000});
      wait_resp(2, "ld");
      finish_resp("ld");
    end

    // Stores of every size; funct3[2] set on one to show it is ignored
    for (int f = 0; f < 4; f++) begin
      d = {$urandom, $urandom};
      a = 64'h8000_0200 + 64'(f * 8);
      issue(1'b1, (f == 2) ? 3'b110 : 3'(f), a, d, 1'b1, 64'd0, 1'b0);
      chk("st_wraddr", oMemWrAddr, a);
      chk("st_wrdata", oMemWrData, d);
      case (f)
        0:       chk("st_wrlen", 64'(oMemWrLen), 64'd1);
        1:       chk("st_wrlen", 64'(oMemWrLen), 64'd2);
        2:       chk("st_wrlen", 64'(oMemWrLen), 64'd4);
        default: chk("st_wrlen", 64'(oMemWrLen), 64'd8);
      endcase
      wait_resp(1, "st");
      finish_resp("st");
    end

    // Response backpressure: stable response, no new accept
    mem_dword  = 64'hA5A5_0102_0304_F0F0;
    iRespReady = 1'b0;
    hold = 64'hA5A5_0102_0304_F0F0;
    issue(1'b0, 3'b011, 64'h8000_0008, '0, 1'b1, hold, 1'b0);
    wait_resp(2, "bp");
    base = rd_pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClock);
      iReqValid  = 1'b1;
      iReqWr     = 1'b0;
      iReqFunct3 = 3'b011;
      iReqAddr   = 64'h8000_0300;
      chk("bp_valid", 64'(oRespValid), 64'd1);
      chk("bp_data", oRespData, hold);
      chk("bp_reqready", 64'(oReqReady), 64'd0);
    end
    @(negedge iClock);
    iReqValid  = 1'b0;
    iRespReady = 1'b1;
    finish_resp("bp");
    @(negedge iClock);
    chk("bp_no_read", 64'(rd_pulses - base), 64'd0);

    // Misaligned accesses
    mem_dword = 64'hDEAD_BEEF_1234_5678;
    base = rd_pulses;
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 3'b010, 64'h8000_0002, '0, 1'b1, 64'd0, 1'b1);
    chk("mis_lw_rden", 64'(oMemRdEn), 64'd0);
    wait_resp(0, "mis_lw");
    finish_resp("mis_lw");
    chk("mis_lw_no_read", 64'(rd_pulses - base), 64'd0);
    base = wr_pulses;
    issue(1'b1, 3'b010, 64'h8000_0006, 64'h55, 1'b1, 64'd0, 1'b1);
    chk("mis_sw_wren", 64'(oMemWrEn), 64'd0);
    wait_resp(0, "mis_sw");
    finish_resp("mis_sw");
    chk("mis_sw_no_write", 64'(wr_pulses - base), 64'd0);
`else
    issue(1'b0, 3'b010, 64'h8000_0002, '0, 1'b1, 64'hFFFF_FFFF_BEEF_1234, 1'b0);
    chk("mis_lw_rden", 64'(oMemRdEn), 64'd1);
    wait_resp(2, "mis_lw");
    finish_resp("mis_lw");
    chk("mis_lw_one_read", 64'(rd_pulses - base), 64'd1);
    issue(1'b0, 3'b011, 64'h8000_0005, '0, 1'b1, 64'h0000_0000_00DE_ADBE, 1'b0);
    wait_resp(2, "mis_ld");
    finish_resp("mis_ld");
    issue(1'b1, 3'b010, 64'h8000_0006, 64'h55, 1'b1, 64'd0, 1'b0);
    chk("mis_sw_wraddr", oMemWrAddr, 64'h8000_0006);
    wait_resp(1, "mis_sw");
    finish_resp("mis_sw");
`endif

    // Reset during RD_DATA discards the request
    mem_dword = 64'h1111_2222_3333_4444;
    issue(1'b0, 3'b011, 64'h8000_0400, '0, 1'b0, '0, 1'b0);
    @(negedge iClock);
    iReset = 1'b1;
    #1;
    chk("mrst_rden", 64'(oMemRdEn), 64'd0);
    chk("mrst_wren", 64'(oMemWrEn), 64'd0);
    chk("mrst_rdaddr", oMemRdAddrLoad, 64'd0);
    chk("mrst_respvalid", 64'(oRespValid), 64'd0);
    chk("mrst_respdata", oRespData, 64'd0);
    @(negedge iClock);
    iReset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClock);
      chk("mrst_no_resp", 64'(oRespValid), 64'd0);
    end
    mem_dword = 64'h0123_8765_4321_0FED;
    a = 64'h8000_0406;
    issue(1'b0, 3'b001, a, '0, 1'b1, model_load(mem_dword, a, 3'b001), 1'b0);
    wait_resp(2, "post_rst");
    finish_resp("post_rst");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
